// File: rtl/tt4_pkg.sv
// Shared types and constants for the 4-input truth-table sweep/capture stage.
package tt4_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int TT_ROWS     = 16;
    localparam int ROW_W       = 4;
    localparam int SYNC_STAGES = 2;

    // Row 0 lands in the hex MSB of the signature.
    function automatic logic [ROW_W-1:0] row_to_bit(input logic [ROW_W-1:0] r);
        return ROW_W'(TT_ROWS - 1) - r;
    endfunction

endpackage

// File: rtl/tt4_sync2.sv
// Two-flop synchronizer for the netlist output, reset to 0.
module tt4_sync2
    import tt4_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_pipe <= '0;
        else        sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], d};
    end

    assign q = sync_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/tt4_sweep_capture.sv
// Sweeps all 16 rows into a 4-input netlist and captures its truth-table signature.
// Optional TT4_SYNC2_EN: synchronize dut_out with two flops and stretch the settle wait to match.
module tt4_sweep_capture
    import tt4_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [15:0] EXPECTED      = 16'hEFEB
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        dut_out,
    output logic        in1,
    output logic        in2,
    output logic        in3,
    output logic        in4,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic        match
);

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("tt4_sweep_capture: SETTLE_CYCLES must be >= 1");
        end
    endgenerate

    logic sample_bit;

`ifdef TT4_SYNC2_EN
    localparam int EXTRA_WAIT = SYNC_STAGES;
    tt4_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dut_out),
        .q     (sample_bit)
    );
`else
    localparam int EXTRA_WAIT = 0;
    assign sample_bit = dut_out;
`endif

    localparam int WAIT_CYC = SETTLE_CYCLES + EXTRA_WAIT;
    localparam int CNT_W    = (WAIT_CYC < 2) ? 1 : $clog2(WAIT_CYC);

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, drv_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [15:0]        sig_q, sig_cap;
    logic               match_q;
    logic               last_row;

    assign last_row = (row_q == ROW_W'(TT_ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        sig_cap = sig_q;
        sig_cap[row_to_bit(row_q)] = sample_bit;
        case (state_q)
            IDLE:    if (start) state_d = DRIVE;
            DRIVE:   state_d = SETTLE;
            SETTLE:  if (cnt_q == '0) state_d = SAMPLE;
            SAMPLE:  state_d = last_row ? DONE : DRIVE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            drv_q   <= '0;
            cnt_q   <= '0;
            sig_q   <= '0;
            match_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    row_q <= '0;
                    drv_q <= '0;
                    sig_q <= '0;
                end
                DRIVE:  cnt_q <= CNT_W'(WAIT_CYC - 1);
                SETTLE: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                SAMPLE: begin
                    sig_q <= sig_cap;
                    // Match is resolved on the last capture so it is valid alongside done.
                    if (last_row) begin
                        match_q <= (sig_cap == EXPECTED);
                    end else begin
                        row_q <= row_q + 1'b1;
                        drv_q <= row_q + 1'b1;
                    end
                end
                DONE:    drv_q <= '0;
                default: ;
            endcase
        end
    end

    assign {in1, in2, in3, in4} = drv_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign signature = sig_q;
    assign match     = match_q;

endmodule
